// File: rtl/text_cell_writer_if.sv
// Command and cell-RAM write bundle for the text cell writer.
// The host side drives commands; the engine side drives writes and status.
interface text_cell_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd;
  logic [15:0] cmd_data;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  modport master (
    output cmd_valid, cmd, cmd_data,
    input  cmd_ready, wr_en, wr_addr, wr_data,
    input  cursor_col, cursor_row, busy
  );

  modport slave (
    input  cmd_valid, cmd, cmd_data,
    output cmd_ready, wr_en, wr_addr, wr_data,
    output cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/text_cell_writer.sv
// Write-side engine for the text cell RAM: cursor, attribute,
// CR/LF handling, auto-advance with wrap and full-area fill.
module text_cell_writer #(
  parameter int          COLS     = 84,
  parameter int          ROWS     = 32,
  parameter logic [7:0]  DEF_ATTR = 8'hF0
) (
  input logic               i_clk,
  input logic               i_rst,
  text_cell_writer_if.slave bus
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  localparam logic [1:0] OP_PUT  = 2'd0;
  localparam logic [1:0] OP_CUR  = 2'd1;
  localparam logic [1:0] OP_ATTR = 2'd2;
  localparam logic [1:0] OP_FILL = 2'd3;

  state_t      state, state_nxt;
  logic [6:0]  col;
  logic [4:0]  row;
  logic [7:0]  attr;
  logic        we_q;
  logic [11:0] addr_q;
  logic [15:0] data_q;

  logic        accept;
  logic        fill_last;
  logic [4:0]  row_inc;
  logic [6:0]  fill_col_n;
  logic [4:0]  fill_row_n;
  logic [7:0]  c;
  logic        unused_bits;

  assign accept      = bus.cmd_valid && (state == IDLE);
  assign fill_last   = (addr_q[11:5] == LAST_COL) && (addr_q[4:0] == LAST_ROW);
  assign row_inc     = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
  assign c           = bus.cmd_data[7:0];
  assign unused_bits = ^bus.cmd_data[15:13];

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.busy       = (state == FILL);
  assign bus.wr_en      = we_q;
  assign bus.wr_addr    = addr_q;
  assign bus.wr_data    = data_q;
  assign bus.cursor_col = col;
  assign bus.cursor_row = row;

  // Next fill address: walk rows first, then step to the next column.
  always_comb begin
    fill_col_n = addr_q[11:5];
    fill_row_n = addr_q[4:0] + 5'd1;
    if (addr_q[4:0] == LAST_ROW) begin
      fill_row_n = 5'd0;
      fill_col_n = addr_q[11:5] + 7'd1;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: enter FILL on a fill command, leave after the last cell.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && bus.cmd == OP_FILL) state_nxt = FILL;
      FILL: if (fill_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Cursor, attribute and registered write port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col    <= '0;
      row    <= '0;
      attr   <= DEF_ATTR;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q <= 1'b0;
      if (state == FILL) begin
        if (fill_last) begin
          col <= '0;
          row <= '0;
        end else begin
          we_q   <= 1'b1;
          addr_q <= {fill_col_n, fill_row_n};
        end
      end else if (accept) begin
        unique case (bus.cmd)
          OP_PUT: begin
            if (c == 8'h0D) begin
              col <= '0;
            end else if (c == 8'h0A) begin
              col <= '0;
              row <= row_inc;
            end else begin
              we_q   <= 1'b1;
              addr_q <= {col, row};
              data_q <= {attr, c};
              if (col == LAST_COL) begin
                col <= '0;
                row <= row_inc;
              end else begin
                col <= col + 7'd1;
              end
            end
          end
          OP_CUR: begin
            col <= (bus.cmd_data[6:0] > LAST_COL)
                   ? LAST_COL : bus.cmd_data[6:0];
            row <= (bus.cmd_data[12:8] > LAST_ROW)
                   ? LAST_ROW : bus.cmd_data[12:8];
          end
          OP_ATTR: attr <= c;
          OP_FILL: begin
            we_q   <= 1'b1;
            addr_q <= '0;
            data_q <= {attr, c};
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_cell_writer.sv
// Self-checking bench for text_cell_writer: directed scenarios plus
// randomized commands against a cursor/attribute reference model.
module tb_text_cell_writer;

  localparam int COLS = 84;
  localparam int ROWS = 32;
  localparam int CELLS = COLS * ROWS;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int   m_col;
  int   m_row;
  int   m_attr;

  text_cell_writer_if bus ();

  text_cell_writer #(
    .COLS(COLS), .ROWS(ROWS), .DEF_ATTR(8'hF0)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one command, wait (bounded) for ready, return 1ns after accept.
  task automatic issue(input int op, input int d);
    int n;
    n = 0;
    bus.cmd       = 2'(op);
    bus.cmd_data  = 16'(d);
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!bus.cmd_ready) begin
      errors++;
      $display("FAIL issue_timeout ready=%0b required=1", bus.cmd_ready);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd       = '0;
    bus.cmd_data  = '0;
    #22;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%0b exp=1", bus.cmd_ready);
    end
    checks++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy} !== 30'd0) begin
      errors++;
      $display("FAIL reset_outputs we=%0b addr=%h data=%h busy=%0b exp=0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy);
    end
    checks++;
    if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL reset_cursor got=(%0d,%0d) exp=(0,0)",
               bus.cursor_col, bus.cursor_row);
    end
  endtask

  task automatic test_put_char();
    issue(0, 16'h0041);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'h000 ||
        bus.wr_data !== 16'hF041) begin
      errors++;
      $display("FAIL put_write we=%0b addr=%h data=%h exp=1/000/F041",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    checks++;
    if (bus.cursor_col !== 7'd1 || bus.cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL put_cursor got=(%0d,%0d) exp=(1,0)",
               bus.cursor_col, bus.cursor_row);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL put_pulse we=%0b exp=0", bus.wr_en);
    end
  endtask

  task automatic test_wrap();
    issue(2, 16'h005A);
    issue(1, (2 << 8) | 83);
    issue(0, 16'h0042);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'hA62 ||
        bus.wr_data !== 16'h5A42) begin
      errors++;
      $display("FAIL wrap_col_write we=%0b addr=%h data=%h exp=1/A62/5A42",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    checks++;
    if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'd3) begin
      errors++;
      $display("FAIL wrap_col_cursor got=(%0d,%0d) exp=(0,3)",
               bus.cursor_col, bus.cursor_row);
    end
    issue(1, (31 << 8) | 83);
    issue(0, 16'h0043);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'hA7F) begin
      errors++;
      $display("FAIL wrap_row_write we=%0b addr=%h exp=1/A7F",
               bus.wr_en, bus.wr_addr);
    end
    checks++;
    if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL wrap_row_cursor got=(%0d,%0d) exp=(0,0)",
               bus.cursor_col, bus.cursor_row);
    end
    issue(1, (31 << 8) | 100);
    checks++;
    if (bus.cursor_col !== 7'd83 || bus.cursor_row !== 5'd31 ||
        bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL cursor_saturate got=(%0d,%0d) we=%0b exp=(83,31) 0",
               bus.cursor_col, bus.cursor_row, bus.wr_en);
    end
  endtask

  task automatic test_crlf();
    issue(1, (5 << 8) | 10);
    issue(0, 16'h000D);
    checks++;
    if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'd5 ||
        bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL cr got=(%0d,%0d) we=%0b exp=(0,5) 0",
               bus.cursor_col, bus.cursor_row, bus.wr_en);
    end
    issue(1, (31 << 8) | 7);
    issue(0, 16'h000A);
    checks++;
    if (bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'd0 ||
        bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL lf_wrap got=(%0d,%0d) we=%0b exp=(0,0) 0",
               bus.cursor_col, bus.cursor_row, bus.wr_en);
    end
  endtask

  task automatic test_random();
    int op, d, ch, exp_we, exp_addr, exp_data;
    issue(1, 0);
    issue(2, 16'h00F0);
    m_col  = 0;
    m_row  = 0;
    m_attr = 8'hF0;
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 2);
      d  = $urandom_range(0, 65535);
      if (op == 0 && $urandom_range(0, 7) == 0)
        d = $urandom_range(0, 1) ? 16'h000D : 16'h000A;
      if (op == 0 && $urandom_range(0, 3) == 0)
        d = (d & 16'hFF00) | 16'h0030;
      ch       = d & 8'hFF;
      exp_we   = 0;
      exp_addr = 0;
      exp_data = 0;
      if (op == 0) begin
        if (ch == 8'h0D) begin
          m_col = 0;
        end else if (ch == 8'h0A) begin
          m_col = 0;
          m_row = (m_row + 1) % ROWS;
        end else begin
          exp_we   = 1;
          exp_addr = m_col * 32 + m_row;
          exp_data = m_attr * 256 + ch;
          m_col    = m_col + 1;
          if (m_col == COLS) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
          end
        end
      end else if (op == 1) begin
        m_col = d & 8'h7F;
        m_row = (d >> 8) & 8'h1F;
        if (m_col > COLS - 1) m_col = COLS - 1;
        if (m_row > ROWS - 1) m_row = ROWS - 1;
      end else begin
        m_attr = ch;
      end
      issue(op, d);
      checks++;
      if (bus.wr_en !== 1'(exp_we)) begin
        errors++;
        $display("FAIL rand_we i=%0d op=%0d got=%0b exp=%0d",
                 i, op, bus.wr_en, exp_we);
      end
      if (exp_we != 0) begin
        checks++;
        if (bus.wr_addr !== 12'(exp_addr) ||
            bus.wr_data !== 16'(exp_data)) begin
          errors++;
          $display("FAIL rand_write i=%0d got=%h/%h exp=%h/%h",
                   i, bus.wr_addr, bus.wr_data, exp_addr, exp_data);
        end
      end
      checks++;
      if (bus.cursor_col !== 7'(m_col) || bus.cursor_row !== 5'(m_row)) begin
        errors++;
        $display("FAIL rand_cursor i=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                 i, bus.cursor_col, bus.cursor_row, m_col, m_row);
      end
    end
  endtask

  task automatic test_fill();
    int bad;
    int k;
    issue(1, (7 << 8) | 9);
    issue(2, 16'h0017);
    issue(3, 16'h0020);
    bus.cmd       = 2'd0;
    bus.cmd_data  = 16'h0055;
    bus.cmd_valid = 1'b1;
    bad = 0;
    k   = 0;
    while (bus.busy === 1'b1 && k < 3000) begin
      checks++;
      if (bus.wr_en !== 1'b1 || bus.cmd_ready !== 1'b0 ||
          bus.wr_addr !== 12'(((k / ROWS) * 32) + (k % ROWS)) ||
          bus.wr_data !== 16'h1720 || bus.cursor_col !== 7'd9 ||
          bus.cursor_row !== 5'd7) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL fill_cell k=%0d we=%0b rdy=%0b addr=%h data=%h",
                   k, bus.wr_en, bus.cmd_ready, bus.wr_addr, bus.wr_data);
      end
      k++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (k != CELLS) begin
      errors++;
      $display("FAIL fill_count got=%0d exp=%0d", k, CELLS);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.wr_en !== 1'b0 ||
        bus.cursor_col !== 7'd0 || bus.cursor_row !== 5'd0) begin
      errors++;
      $display("FAIL fill_end busy=%0b rdy=%0b we=%0b cur=(%0d,%0d)",
               bus.busy, bus.cmd_ready, bus.wr_en,
               bus.cursor_col, bus.cursor_row);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'h000 ||
        bus.wr_data !== 16'h1755 || bus.cursor_col !== 7'd1) begin
      errors++;
      $display("FAIL fill_held_put we=%0b addr=%h data=%h col=%0d exp=1/000/1755/1",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.cursor_col);
    end
  endtask

  task automatic test_reset_mid_fill();
    issue(3, 16'h002A);
    repeat (99) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'h063 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL fill_100th we=%0b addr=%h busy=%0b exp=1/063/1",
               bus.wr_en, bus.wr_addr, bus.busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_abort we=%0b busy=%0b exp=0/0",
               bus.wr_en, bus.busy);
    end
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.cursor_col !== 7'd0 ||
        bus.cursor_row !== 5'd0 || bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL post_reset rdy=%0b cur=(%0d,%0d) we=%0b",
               bus.cmd_ready, bus.cursor_col, bus.cursor_row, bus.wr_en);
    end
    issue(0, 16'h0030);
    checks++;
    if (bus.wr_data !== 16'hF030 || bus.wr_addr !== 12'h000) begin
      errors++;
      $display("FAIL post_reset_attr got=%h/%h exp=F030/000",
               bus.wr_data, bus.wr_addr);
    end
  endtask

  task automatic test_back_to_back();
    issue(1, (4 << 8) | 82);
    issue(2, 16'h0063);
    issue(0, 16'h0061);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'(82 * 32 + 4)) begin
      errors++;
      $display("FAIL b2b_first we=%0b addr=%h", bus.wr_en, bus.wr_addr);
    end
    issue(0, 16'h0062);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'(83 * 32 + 4) ||
        bus.wr_data !== 16'h6362) begin
      errors++;
      $display("FAIL b2b_second we=%0b addr=%h data=%h",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    issue(0, 16'h0063);
    checks++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 12'(0 * 32 + 5)) begin
      errors++;
      $display("FAIL b2b_third we=%0b addr=%h", bus.wr_en, bus.wr_addr);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_put_char();
    test_wrap();
    test_crlf();
    test_back_to_back();
    test_random();
    test_fill();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
